// File: rtl/pci_master.sv
// PCI initiator: one address phase then 1..8 data phases at 32 or 64 bits,
// with master abort, target abort, disconnect/retry and parity generation.
module pci_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [2:0]  len,
    input  logic        wide,
    input  logic [63:0] wdata,
    input  logic [7:0]  byte_en,
    output logic        wdata_ack,
    output logic [63:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    inout  wire  [63:0] ad,
    inout  wire  [7:0]  c_be,
    inout  wire         frame,
    inout  wire         irdy,
    inout  wire         req64,
    input  logic        trdy,
    input  logic        devsel,
    input  logic        stop,
    input  logic        ack64,
    inout  wire         par,
    inout  wire         par64
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, TERM, TURN} state_t;

    state_t      state_q;
    logic [3:0]  cmd_q;
    logic [31:0] addr_q;
    logic [2:0]  len_q;
    logic [2:0]  cnt_q;
    logic [2:0]  dto_q;
    logic        wide_q;
    logic        first_q;
    logic        seen_q;
    logic [1:0]  status_q;
    logic [63:0] rdata_q;
    logic        rvalid_q;
    logic        done_q;
    logic        par_q;
    logic        par64_q;
    logic        par_oe_q;

    logic        is_wr;
    logic        in_data;
    logic        in_dt;
    logic        last;
    logic        xfer;
    logic        bus_oe;
    logic        frame_o;
    logic        irdy_o;
    logic        req64_o;
    logic        lo_oe;
    logic        hi_oe;
    logic        cbe_oe;
    logic [31:0] ad_lo;
    logic [31:0] ad_hi;
    logic [7:0]  cbe_o;

    always_comb begin
        is_wr   = cmd_q[0];
        in_data = state_q == DATA;
        in_dt   = in_data || state_q == TERM;
        last    = cnt_q == len_q;
        // The first data cycle of a read is bus turnaround and never transfers.
        xfer    = in_data && !trdy && (is_wr || !first_q);
        bus_oe  = state_q != IDLE;
        frame_o = (state_q == ADDR) ? 1'b0 : (in_data ? last : 1'b1);
        irdy_o  = !in_dt;
        req64_o = !(wide_q && !frame_o);
        lo_oe   = state_q == ADDR || (in_dt && is_wr);
        hi_oe   = state_q == ADDR || (in_dt && is_wr && wide_q);
        cbe_oe  = state_q == ADDR || in_dt;
        ad_lo   = (state_q == ADDR) ? addr_q : wdata[31:0];
        ad_hi   = (state_q == ADDR) ? 32'h0 : wdata[63:32];
        cbe_o   = (state_q == ADDR) ? {4'h0, cmd_q} : ~byte_en;
    end

    assign ad[31:0]    = lo_oe ? ad_lo : 32'hz;
    assign ad[63:32]   = hi_oe ? ad_hi : 32'hz;
    assign c_be        = cbe_oe ? cbe_o : 8'hz;
    assign frame       = bus_oe ? frame_o : 1'bz;
    assign irdy        = bus_oe ? irdy_o : 1'bz;
    assign req64       = bus_oe ? req64_o : 1'bz;
    assign par         = par_oe_q ? par_q : 1'bz;
    assign par64       = (par_oe_q && wide_q) ? par64_q : 1'bz;
    assign wdata_ack   = xfer && is_wr;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign busy        = bus_oe;
    assign done        = done_q;
    assign status      = status_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cmd_q    <= 4'h0;
            addr_q   <= 32'h0;
            len_q    <= 3'd0;
            cnt_q    <= 3'd0;
            dto_q    <= 3'd0;
            wide_q   <= 1'b0;
            first_q  <= 1'b0;
            seen_q   <= 1'b0;
            status_q <= 2'b00;
            rdata_q  <= 64'h0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            par_q    <= 1'b0;
            par64_q  <= 1'b0;
            par_oe_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            par_q    <= ^{ad_lo, cbe_o[3:0]};
            par64_q  <= ^{ad_hi, cbe_o[7:4]};
            par_oe_q <= lo_oe;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= ADDR;
                        cmd_q    <= cmd;
                        addr_q   <= addr;
                        len_q    <= len;
                        wide_q   <= wide;
                        cnt_q    <= 3'd0;
                        status_q <= 2'b00;
                    end
                end
                ADDR: begin
                    state_q <= DATA;
                    first_q <= 1'b1;
                    seen_q  <= 1'b0;
                    dto_q   <= 3'd0;
                end
                DATA: begin
                    first_q <= 1'b0;
                    seen_q  <= seen_q || !devsel;
                    if (!seen_q && devsel) dto_q <= dto_q + 3'd1;
                    if (xfer) begin
                        cnt_q <= cnt_q + 3'd1;
                        if (!is_wr) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= (wide_q && !ack64) ? ad : {32'h0, ad[31:0]};
                        end
                    end
                    if (!stop) begin
                        state_q  <= TERM;
                        status_q <= devsel ? 2'b11 : 2'b10;
                    end else if (xfer && last) begin
                        state_q  <= TURN;
                        status_q <= 2'b00;
                    end else if (!seen_q && devsel && dto_q == 3'd4) begin
                        state_q  <= TERM;
                        status_q <= 2'b01;
                    end
                end
                TERM: state_q <= TURN;
                TURN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_master.sv
// Bench for pci_master: directed table and random transactions against a
// scripted PCI target and a per-transaction outcome predictor.
module tb_pci_master;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cmd = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  len = 3'd0;
    logic        wide = 1'b0;
    logic [63:0] wdata = 64'h0;
    logic [7:0]  byte_en = 8'h0;
    logic        trdy = 1'b1;
    logic        devsel = 1'b1;
    logic        stop = 1'b1;
    logic        ack64 = 1'b1;
    logic        wdata_ack;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    wire  [63:0] ad;
    wire  [7:0]  c_be;
    wire         frame;
    wire         irdy;
    wire         req64;
    wire         par;
    wire         par64;
    logic        t_oe = 1'b0;
    logic [63:0] t_ad = 64'h0;
    int          nvec = 0;
    int          nerr = 0;

    typedef struct {
        logic [3:0]  c;
        logic [2:0]  l;
        logic        w;
        logic        a64;
        int          dlat;
        int          mode;
        int          dph;
        int          waits;
        logic [31:0] a;
        logic [1:0]  st;
        int          n;
    } vec_t;

    vec_t tbl [10];

    assign ad = t_oe ? t_ad : 64'hz;
    pullup pu_frame (frame);
    pullup pu_irdy (irdy);
    pullup pu_req64 (req64);
    pullup pu_par (par);
    pullup pu_par64 (par64);

    always #5 clk = ~clk;

    pci_master dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
        .len(len), .wide(wide), .wdata(wdata), .byte_en(byte_en),
        .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy), .done(done), .status(status), .ad(ad), .c_be(c_be),
        .frame(frame), .irdy(irdy), .req64(req64), .trdy(trdy),
        .devsel(devsel), .stop(stop), .ack64(ack64), .par(par), .par64(par64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Outcome from the target's script: modes 0 normal, 1 disconnect with
    // data, 2 retry without data, 3 target abort, all at phase dph.
    function automatic void predict(input int l, input int dlat, input int mode,
                                    input int dph, output logic [1:0] st, output int n);
        if (dlat >= 5) begin
            st = 2'b01; n = 0;
        end else begin
            case (mode)
                0: begin st = 2'b00; n = l + 1; end
                1: begin st = 2'b10; n = dph + 1; end
                2: begin st = 2'b10; n = dph; end
                default: begin st = 2'b11; n = dph; end
            endcase
        end
    endfunction

    task automatic run_txn(input logic [3:0] c, input logic [2:0] l, input logic w,
                           input logic a64, input int dlat, input int mode,
                           input int dph, input int waits, input logic [31:0] a,
                           input logic [63:0] w0, input logic [1:0] exp_st,
                           input int exp_cnt);
        logic [63:0] words [8];
        logic [63:0] rexp [$];
        logic [63:0] m;
        int k, tcnt, nxf, widx;
        bit quiet, got, is_wr, x;
        is_wr = c[0];
        m = (w && a64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
        foreach (words[i]) words[i] = {$urandom, $urandom};
        words[0] = w0;
        k = 0; tcnt = 0; nxf = 0; widx = 0; quiet = 0; got = 0;
        cmd = c; len = l; wide = w; addr = a; wdata = words[0];
        byte_en = 8'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("addr_frame", 64'(frame), 64'(0));
        chk("addr_irdy", 64'(irdy), 64'(1));
        chk("addr_ad", ad, {32'h0, a});
        chk("addr_cmd", 64'(c_be[3:0]), 64'(c));
        chk("addr_req64", 64'(req64), 64'(!w));
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            @(posedge clk); #1;
            t_oe = 1'b0; trdy = 1'b1; devsel = 1'b1; stop = 1'b1; ack64 = 1'b1;
            x = 0;
            if (rdata_valid) begin
                if (rexp.size() == 0) chk("rdata_extra", 64'(1), 64'(0));
                else chk("rdata", rdata, rexp.pop_front());
                nxf++;
            end
            if (done) begin
                got = 1;
            end else begin
                if (widx < 8) wdata = words[widx];
                if (irdy == 1'b0) begin
                    if (k == 0) chk("par_addr", 64'(par), 64'(^{a, c}));
                    if (!quiet && (dlat < 5 || k < 5))
                        chk("data_frame", 64'(frame), 64'(tcnt == int'(l)));
                    if (!quiet && dlat < 5 && k >= dlat && tcnt <= int'(l)) begin
                        devsel = 1'b0;
                        ack64 = !(w && a64);
                        if ((is_wr || k >= 1) && (waits == 0 || $urandom_range(0, 2) != 0)) begin
                            if (mode != 0 && tcnt == dph) begin
                                quiet = 1;
                                stop = 1'b0;
                                if (mode == 1) begin trdy = 1'b0; x = 1; end
                                if (mode == 3) devsel = 1'b1;
                            end else begin
                                trdy = 1'b0; x = 1;
                            end
                        end
                        if (x) begin
                            if (!is_wr) begin
                                t_oe = 1'b1;
                                t_ad = words[tcnt];
                                rexp.push_back(words[tcnt] & m);
                            end
                            tcnt++;
                        end
                    end
                    k++;
                end
                #1;
                chk("wdata_ack", 64'(wdata_ack), 64'(x && is_wr));
                if (wdata_ack) begin
                    if (x && is_wr) chk("wdata_bus", ad & m, words[tcnt - 1] & m);
                    widx++;
                end
            end
        end
        t_oe = 1'b0; trdy = 1'b1; devsel = 1'b1; stop = 1'b1; ack64 = 1'b1;
        chk("done_seen", 64'(got), 64'(1));
        chk("status", 64'(status), 64'(exp_st));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("xfer_count", 64'(is_wr ? widx : nxf), 64'(exp_cnt));
        chk("rdata_left", 64'(rexp.size()), 64'(0));
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'(0));
        chk("frame_released", 64'(frame), 64'(1));
        chk("req64_released", 64'(req64), 64'(1));
    endtask

    initial begin
        logic [1:0] pst;
        int pn, dl, md, dp;
        logic [2:0] rl;
        tbl[0] = '{4'b0111, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 32'h100,  2'b00, 1};
        tbl[1] = '{4'b0110, 3'd3, 1'b1, 1'b1, 0, 0, 0, 0, 32'h2000, 2'b00, 4};
        tbl[2] = '{4'b0110, 3'd3, 1'b1, 1'b0, 1, 0, 0, 1, 32'h3000, 2'b00, 4};
        tbl[3] = '{4'b0111, 3'd7, 1'b1, 1'b1, 2, 0, 0, 1, 32'h4000, 2'b00, 8};
        tbl[4] = '{4'b0111, 3'd2, 1'b0, 1'b0, 5, 0, 0, 0, 32'h5000, 2'b01, 0};
        tbl[5] = '{4'b0110, 3'd0, 1'b0, 1'b0, 4, 0, 0, 0, 32'h6000, 2'b00, 1};
        tbl[6] = '{4'b0110, 3'd3, 1'b0, 1'b0, 0, 2, 0, 0, 32'h7000, 2'b10, 0};
        tbl[7] = '{4'b0111, 3'd5, 1'b0, 1'b0, 0, 1, 2, 1, 32'h8000, 2'b10, 3};
        tbl[8] = '{4'b0111, 3'd3, 1'b1, 1'b1, 0, 3, 2, 0, 32'h9000, 2'b11, 2};
        tbl[9] = '{4'b0110, 3'd4, 1'b0, 1'b0, 1, 3, 1, 1, 32'hA000, 2'b11, 1};

        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_wack", 64'(wdata_ack), 64'(0));
        chk("rst_rvalid", 64'(rdata_valid), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_frame", 64'(frame), 64'(1));
        chk("rst_irdy", 64'(irdy), 64'(1));
        chk("rst_par64", 64'(par64), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_txn(tbl[i].c, tbl[i].l, tbl[i].w, tbl[i].a64, tbl[i].dlat,
                    tbl[i].mode, tbl[i].dph, tbl[i].waits, tbl[i].a,
                    64'h0000_0000_0000_a5a5, tbl[i].st, tbl[i].n);

        // Asynchronous reset in the middle of a write burst.
        cmd = 4'b0111; len = 3'd3; wide = 1'b0; addr = 32'h1234_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_irdy", 64'(irdy), 64'(0));
        #2 rst = 1'b0;
        #1;
        chk("arst_frame", 64'(frame), 64'(1));
        chk("arst_irdy", 64'(irdy), 64'(1));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_status", 64'(status), 64'(0));
        chk("arst_par", 64'(par), 64'(1));
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst_no_done", 64'(done), 64'(0));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(4'b0111, 3'd1, 1'b0, 1'b0, 0, 0, 0, 0, 32'h40, 64'h55, 2'b00, 2);

        for (int t = 0; t < 40; t++) begin
            rl = 3'($urandom);
            dl = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            dp = int'($urandom_range(0, int'(rl)));
            predict(int'(rl), dl, md, dp, pst, pn);
            run_txn(4'($urandom), rl, 1'($urandom), 1'($urandom), dl, md, dp,
                    int'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, pst, pn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pci_master.md
PCI_MASTER -- requirements
Module: pci_master

Interface
REQ-001 clk  input  1  PCI clock; all state changes on the rising edge.
REQ-002 rst  input  1  Asynchronous, active-low reset.
REQ-003 start  input  1  One-cycle request pulse, sampled only in IDLE.
REQ-004 cmd  input  4  PCI command driven on c_be[3:0] in the address phase; cmd[0]=1 means write, 0 means read.
REQ-005 addr  input  32  Transaction start address.
REQ-006 len  input  3  Number of data phases minus 1, giving 1..8 phases.
REQ-007 wide  input  1  Request a 64-bit transfer through req64.
REQ-008 wdata / byte_en  input  64 / 8  Write data and active-high byte enables for the current phase.
REQ-009 wdata_ack  output  1  Pulse: current write phase completed; user presents the next word.
REQ-010 rdata / rdata_valid  output  64 / 1  Read data captured on a completed phase, with a one-cycle strobe.
REQ-011 busy / done  output  1 / 1  busy: not IDLE; done: one-cycle pulse on return to IDLE.
REQ-012 status  output  2  Final result: 00 ok, 01 master abort, 10 retry/disconnect, 11 target abort; held until the next start.
REQ-013 ad, c_be  inout  64, 8  PCI address/data and command/byte-enable lines; c_be is active-low.
REQ-014 frame, irdy, req64  inout  1 each  Active-low initiator controls; high-Z when the bus is not owned.
REQ-015 trdy, devsel, stop, ack64  input  1 each  Active-low target responses.
REQ-016 par, par64  inout  1 each  Even parity over ad[31:0]+c_be[3:0] and ad[63:32]+c_be[7:4].

Function
REQ-017 States: IDLE, ADDR, DATA, TERM, TURN.
REQ-018 IDLE to ADDR on start=1, which latches cmd, addr, len and wide.
REQ-019 ADDR (one cycle) drives frame=0, ad[31:0]=addr, ad[63:32]=0, c_be[3:0]=cmd, and req64=0 iff wide=1.
REQ-020 ADDR always moves to DATA.
REQ-021 DATA drives irdy=0; for writes it drives ad=wdata and c_be=~byte_en.
REQ-022 For reads in DATA, ad is released and c_be=~byte_en is driven; the first DATA cycle of a read is turnaround, and no transfer is counted even if trdy=0.
REQ-023 A phase completes on an edge where irdy=0 and trdy=0 are both sampled; completion increments the phase counter.
REQ-024 On a completed read phase, rdata is updated and rdata_valid is pulsed.
REQ-025 On a completed write phase, wdata_ack is pulsed.
REQ-026 frame is deasserted (1), with irdy held at 0, in the cycle that presents the final phase (counter==len).
REQ-027 If ack64 is sampled high while devsel=0, the width is 32-bit: ad[63:32] is undriven or ignored, and each phase carries ad[31:0] only.
REQ-028 Master abort: if devsel stays high for 5 clocks after ADDR, the block goes to TERM with status=01.
REQ-029 stop=0 with devsel=0: disconnect; the current phase counts if trdy=0; the block goes to TERM with status=10.
REQ-030 stop=0 with devsel=1: target abort; the block goes to TERM with status=11.
REQ-031 TERM (one cycle) drives frame=1 and irdy=0, then the block goes to TURN.
REQ-032 TURN (one cycle) drives frame, irdy and req64 high, then releases all driven lines to Z; done is pulsed as the block enters IDLE.
REQ-033 Normal completion of the last phase goes directly to TURN with status=00.
REQ-034 par and par64 are driven in the cycle after each address or write-data cycle and released one cycle after the last one.
REQ-035 start while busy=1 is ignored.

Reset
REQ-036 rst=0 forces IDLE and clears the counter.
REQ-037 While rst=0, all inouts are Z and busy, done, wdata_ack and rdata_valid are 0.
REQ-038 While rst=0, status=00 and rdata=0.
REQ-039 Reset during any state aborts the transaction without a done pulse.

Verification
REQ-040 Single 32-bit write (cmd=0111, len=0, addr=0x100, wdata=0xA5A5): ADDR drives frame=0 and ad=0x100; target asserts devsel/trdy in cycle 2 -> one wdata_ack, frame high during the data phase, done, status=00.
REQ-041 4-phase 64-bit read (wide=1, ack64=0): turnaround cycle counted 0; 4 rdata_valid pulses carrying the target's 64-bit values; req64 released in TURN.
REQ-042 No devsel for 5 clocks -> TERM, then TURN, then done with status=01.
REQ-043 Retry: stop=0 with trdy=1 on the first phase -> no transfer counted, done, status=10.
REQ-044 Target abort: devsel rises while stop=0 mid-burst -> status=11.
REQ-045 Async reset asserted in DATA: all lines Z immediately and no done pulse; a subsequent start operates normally.
